neuron_lut_prog: RTL and testbench
==================================

NEURON_LUT_PROG -- requirements
Module: neuron_lut_prog

Interface
REQ-001 Parameter IN_BITS, default 8: width of the packed activation input M0; the table depth is 2^IN_BITS.
REQ-002 Parameter OUT_BITS, default 2: width of each table entry and of the output M1.
REQ-003 Parameter CFG_W, default 8: config beat width; each beat carries CFG_W/OUT_BITS entries (4 at default).
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port cfg_start, input, 1: single-cycle request to begin loading the table.
REQ-007 Port cfg_valid, input, 1: cfg_data holds a valid beat.
REQ-008 Port cfg_data, input, CFG_W: packed table entries; the entry for the lower address sits in the LSBs.
REQ-009 Port cfg_ready, output, 1: the block accepts a beat this cycle.
REQ-010 Port cfg_done, output, 1: one-cycle pulse when the table load completes.
REQ-011 Port in_valid, input, 1: M0 holds a valid activation vector.
REQ-012 Port M0, input, IN_BITS: packed quantized activations, used as the table address.
REQ-013 Port out_valid, output, 1: M1 is valid.
REQ-014 Port M1, output, OUT_BITS: quantized neuron output.
REQ-015 Port table_valid, output, 1: the table holds a complete, consistent load.

Function
REQ-016 The block SHALL implement a 3-state FSM: EMPTY, LOAD, ACTIVE.
REQ-017 EMPTY SHALL be the reset state.
REQ-018 In any state, cfg_start=1 SHALL cause the next state to be LOAD, clear the beat counter to 0, and deassert table_valid.
REQ-019 cfg_ready SHALL equal 1 exactly when the state is LOAD.
REQ-020 A beat SHALL be accepted when cfg_valid=1, cfg_ready=1 and cfg_start=0.
REQ-021 On acceptance, entry j of the beat (bits [OUT_BITS*j+OUT_BITS-1 : OUT_BITS*j]) SHALL be written to address beat_cnt*(CFG_W/OUT_BITS)+j, and beat_cnt SHALL increment.
REQ-022 When the last beat is accepted (beat_cnt = 2^IN_BITS/(CFG_W/OUT_BITS)-1, i.e. 63 at defaults), the block SHALL:
- set the next state to ACTIVE;
- set table_valid=1 from the next cycle;
- pulse cfg_done for exactly one cycle (the next cycle).
REQ-023 If cfg_start and cfg_valid are both 1 in LOAD, the beat SHALL be discarded and the load restarted at beat 0.
REQ-024 cfg_valid while not in LOAD SHALL be ignored; table contents SHALL be unchanged.
REQ-025 Lookup SHALL be registered with 1-cycle latency:
- out_valid(t+1) = in_valid(t);
- M1(t+1) = table[M0(t)] if the state at t is ACTIVE, else 0.
REQ-026 When in_valid=0, M1 SHALL hold its previous value.
REQ-027 A lookup issued in the same cycle as the final config beat SHALL return 0, because the state is still LOAD.
REQ-028 A lookup issued in the same cycle as cfg_start while ACTIVE SHALL return the old table value.
REQ-029 The table SHALL be 2^IN_BITS x OUT_BITS distributed storage and SHALL NOT be cleared by reset.
REQ-030 Table contents SHALL be unobservable until table_valid=1.
REQ-031 The beat counter SHALL NOT wrap; after the final beat, the FSM SHALL leave LOAD.

Reset
REQ-032 While rst=0, the block SHALL hold: state=EMPTY, beat_cnt=0, cfg_ready=0, cfg_done=0, out_valid=0, M1=0, table_valid=0.
REQ-033 A reset asserted mid-load SHALL abort the load; after release, the block SHALL sit in EMPTY until the next cfg_start, and all lookups SHALL return 0.
REQ-034 Reset release SHALL take effect synchronously on the first clk edge where rst=1; no transfer occurs on that edge's preceding cycle.

Verification
REQ-035 Full load of a known table (entry a = popcount(a) mod 4), then sweep all 256 M0 values -> each M1 matches one cycle later; table_valid=1; cfg_done pulsed once.
REQ-036 Load with random cfg_valid gaps -> identical result to a gapless load; cfg_done is asserted only after the 64th accepted beat.
REQ-037 cfg_start after 30 beats, then a full 64-beat load of a second table -> lookups reflect only the second table; no partial entries from the aborted load remain.
REQ-038 in_valid=1 with M0=8'h0C in EMPTY, in LOAD, and in the final-beat cycle -> out_valid=1 and M1=2'b00 each time; in ACTIVE -> the programmed value.
REQ-039 rst pulse at beat 40 -> outputs go to reset values immediately; cfg_valid afterwards is ignored (cfg_ready=0) until cfg_start.
REQ-040 cfg_start while ACTIVE with concurrent in_valid -> the same-cycle lookup returns the old entry; the next lookup returns 0; table_valid drops the following cycle.

Source files
------------

// File: rtl/neuron_lut_prog.sv
// neuron_lut_prog: programmable lookup-table neuron.
//
// A 2^IN_BITS x OUT_BITS table maps a packed activation vector (M0) to a
// quantized neuron output (M1). The table is loaded through a beat-oriented
// config port. Each beat carries CFG_W/OUT_BITS entries, and the lowest
// address is in the LSBs. Lookups are answered only once a complete load
// has finished (ACTIVE). In any other state a lookup returns 0.
//
// Ports:
//   clk         - clock; all state changes on the rising edge
//   rst         - asynchronous active-low reset
//   cfg_start   - one-cycle request to (re)start a table load
//   cfg_valid   - cfg_data carries a valid beat
//   cfg_data    - packed table entries for one beat
//   cfg_ready   - a beat is accepted this cycle (state is LOAD)
//   cfg_done    - one-cycle pulse after the final beat is accepted
//   in_valid    - M0 carries a valid activation vector
//   M0          - table address (packed activations)
//   out_valid   - M1 is valid (in_valid delayed by one cycle)
//   M1          - looked-up neuron output
//   table_valid - the table holds a complete load
module neuron_lut_prog #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int CFG_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [CFG_W-1:0]    cfg_data,
  output logic                cfg_ready,
  output logic                cfg_done,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  M0,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] M1,
  output logic                table_valid
);

  localparam int EPB     = CFG_W / OUT_BITS;          // entries per beat
  localparam int LOG_EPB = $clog2(EPB);
  localparam int DEPTH   = 1 << IN_BITS;
  localparam int BEATS   = DEPTH / EPB;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      beat_cnt;
  logic [OUT_BITS-1:0]   tbl [0:DEPTH-1];

  logic                  beat_accept;
  logic                  last_beat;
  logic [IN_BITS-1:0]    beat_base;

  // A start request always wins over a beat presented in the same cycle.
  assign beat_accept = (state == LOAD) && cfg_valid && !cfg_start;
  assign last_beat   = (beat_cnt == CNT_W'(BEATS - 1));
  assign beat_base   = IN_BITS'(beat_cnt) << LOG_EPB;
  assign cfg_ready   = (state == LOAD);

  // Table write port: deliberately has no reset so contents survive rst;
  // they are hidden by the ACTIVE gate on the read side instead.
  always_ff @(posedge clk) begin
    if (beat_accept) begin
      for (int j = 0; j < EPB; j++) begin
        tbl[beat_base + IN_BITS'(j)] <= cfg_data[OUT_BITS*j +: OUT_BITS];
      end
    end
  end

  // Load FSM, beat counter and registered lookup output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= EMPTY;
      beat_cnt    <= {CNT_W{1'b0}};
      cfg_done    <= 1'b0;
      table_valid <= 1'b0;
      out_valid   <= 1'b0;
      M1          <= {OUT_BITS{1'b0}};
    end else begin
      cfg_done  <= 1'b0;
      out_valid <= in_valid;

      // Uses the current state, so a lookup in the cfg_start cycle still
      // sees the old table and one in the final-beat cycle still sees LOAD.
      if (in_valid) begin
        M1 <= (state == ACTIVE) ? tbl[M0] : {OUT_BITS{1'b0}};
      end else begin
        M1 <= M1;
      end

      if (cfg_start) begin
        state       <= LOAD;
        beat_cnt    <= {CNT_W{1'b0}};
        table_valid <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (cfg_valid) begin
              if (last_beat) begin
                // Counter holds at its final value rather than wrapping.
                state       <= ACTIVE;
                table_valid <= 1'b1;
                cfg_done    <= 1'b1;
              end else begin
                beat_cnt <= beat_cnt + CNT_W'(1);
              end
            end else begin
              beat_cnt <= beat_cnt;
            end
          end
          EMPTY, ACTIVE: begin
            state <= state;
          end
          default: begin
            // Unreachable encoding: fall back to the safe empty state.
            state       <= EMPTY;
            table_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neuron_lut_prog.sv
module tb_neuron_lut_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic       cfg_done;
  logic       in_valid;
  logic [7:0] M0;
  logic       out_valid;
  logic [1:0] M1;
  logic       table_valid;

  int total = 0;
  int bad   = 0;

  neuron_lut_prog #(.IN_BITS(8), .OUT_BITS(2), .CFG_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .cfg_done   (cfg_done),
    .in_valid   (in_valid),
    .M0         (M0),
    .out_valid  (out_valid),
    .M1         (M1),
    .table_valid(table_valid)
  );

  always #5 clk = ~clk;

  // Reference tables: 0 = popcount mod 4, 1 = xor pattern, 2 = complement of 1's LSB
  function automatic logic [1:0] ent(input int kind, input int a);
    int pc;
    pc = 0;
    for (int i = 0; i < 8; i++) pc += (a >> i) & 1;
    case (kind)
      0:       return 2'(pc % 4);
      1:       return 2'((a ^ (a >> 3)) & 3);
      default: return 2'(((a ^ (a >> 3)) & 3) ^ 1);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    total++;
    if (cfg_ready !== 1'b0 || cfg_done !== 1'b0 || out_valid !== 1'b0 ||
        M1 !== 2'b00 || table_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s: ready=%b done=%b ov=%b M1=%b tv=%b want all 0",
               tag, cfg_ready, cfg_done, out_valid, M1, table_valid);
    end
  endtask

  // Start a load (with a beat that must be discarded in the start cycle) and
  // push nbeats beats, probing a lookup of 8'h0C every cycle (must read 0).
  task automatic do_load(input int kind, input int nbeats, input bit gaps);
    int b, guard, dones;
    bit acc;
    logic [7:0] d;
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hA5; in_valid = 1'b0;
    step();
    cfg_start = 1'b0;
    total++;
    if (cfg_ready !== 1'b1 || table_valid !== 1'b0) begin
      bad++;
      $display("FAIL load_enter: ready=%b tv=%b want 1/0", cfg_ready, table_valid);
    end
    b = 0; guard = 0; dones = 0;
    while (b < nbeats && guard < 1000) begin
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        cfg_valid = 1'b0;
      end else begin
        for (int j = 0; j < 4; j++) d[2*j +: 2] = ent(kind, b*4 + j);
        cfg_valid = 1'b1;
        cfg_data  = d;
      end
      in_valid = 1'b1; M0 = 8'h0C;
      acc = cfg_valid && cfg_ready;
      step();
      if (acc) b++;
      total++;
      if (out_valid !== 1'b1 || M1 !== 2'b00) begin
        bad++;
        $display("FAIL load_lookup beat %0d: ov=%b M1=%b want 1/00", b, out_valid, M1);
      end
      if (cfg_done === 1'b1) begin
        dones++;
        total++;
        if (b != 64) begin
          bad++;
          $display("FAIL early_done: cfg_done after %0d beats want 64", b);
        end
      end
    end
    cfg_valid = 1'b0; in_valid = 1'b0;
    total++;
    if (guard >= 1000) begin
      bad++;
      $display("FAIL load_timeout: accepted %0d beats want %0d", b, nbeats);
    end
    total++;
    if (dones != ((nbeats == 64) ? 1 : 0)) begin
      bad++;
      $display("FAIL done_count: %0d pulses want %0d", dones, (nbeats == 64) ? 1 : 0);
    end
    if (nbeats == 64) begin
      total++;
      if (cfg_ready !== 1'b0 || table_valid !== 1'b1) begin
        bad++;
        $display("FAIL load_end: ready=%b tv=%b want 0/1", cfg_ready, table_valid);
      end
      step();
      total++;
      if (cfg_done !== 1'b0 || table_valid !== 1'b1) begin
        bad++;
        $display("FAIL done_pulse: done=%b tv=%b want 0/1", cfg_done, table_valid);
      end
    end
  endtask

  task automatic sweep(input int kind);
    for (int a = 0; a < 256; a++) begin
      in_valid = 1'b1; M0 = 8'(a);
      step();
      total++;
      if (out_valid !== 1'b1 || M1 !== ent(kind, a)) begin
        bad++;
        $display("FAIL sweep_k%0d a=%0d: ov=%b M1=%b want 1/%b", kind, a, out_valid, M1, ent(kind, a));
      end
    end
    in_valid = 1'b0; M0 = 8'h00;
    step();
    total++;
    if (out_valid !== 1'b0 || M1 !== ent(kind, 255)) begin
      bad++;
      $display("FAIL hold: ov=%b M1=%b want 0/%b", out_valid, M1, ent(kind, 255));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b1; cfg_data = 8'hFF;
    in_valid = 1'b1; M0 = 8'h0C;
    #2;
    check_idle_outputs("reset_async");
    step(); step();
    check_idle_outputs("reset_held");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (cfg_ready !== 1'b0 || table_valid !== 1'b0 || out_valid !== 1'b1 || M1 !== 2'b00) begin
        bad++;
        $display("FAIL empty_lookup: ready=%b tv=%b ov=%b M1=%b want 0/0/1/00",
                 cfg_ready, table_valid, out_valid, M1);
      end
    end
    cfg_valid = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_full_load();
    do_load(0, 64, 1'b0);
    sweep(0);
  endtask

  task automatic test_gap_load();
    do_load(1, 64, 1'b1);
    sweep(1);
  endtask

  task automatic test_abort_reload();
    do_load(2, 30, 1'b0);
    do_load(0, 64, 1'b0);
    sweep(0);
  endtask

  task automatic test_restart_active();
    // Table holds kind 0: entry 0x0C = popcount(12) mod 4 = 2
    cfg_start = 1'b1; in_valid = 1'b1; M0 = 8'h0C;
    step();
    cfg_start = 1'b0;
    total++;
    if (out_valid !== 1'b1 || M1 !== 2'b10 || table_valid !== 1'b0) begin
      bad++;
      $display("FAIL restart_old: ov=%b M1=%b tv=%b want 1/10/0", out_valid, M1, table_valid);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || M1 !== 2'b00) begin
      bad++;
      $display("FAIL restart_next: ov=%b M1=%b want 1/00", out_valid, M1);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midload();
    do_load(2, 40, 1'b0);
    in_valid = 1'b1; M0 = 8'h0C;
    rst = 1'b0;
    #1;
    check_idle_outputs("midload_reset");
    @(negedge clk);
    rst = 1'b1;
    cfg_valid = 1'b1; cfg_data = 8'h55;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (cfg_ready !== 1'b0 || table_valid !== 1'b0 || cfg_done !== 1'b0 || M1 !== 2'b00) begin
        bad++;
        $display("FAIL post_reset: ready=%b tv=%b done=%b M1=%b want 0/0/0/00",
                 cfg_ready, table_valid, cfg_done, M1);
      end
    end
    cfg_valid = 1'b0; in_valid = 1'b0;
    do_load(1, 64, 1'b0);
    sweep(1);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_gap_load();
    test_abort_reload();
    test_restart_active();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
